// File: rtl/ucode_pkg.sv
// ucode_pkg: shared definitions for the microcode sequencer.
//   next_sel_e  - next-address selector held in the N field of a microword
//   sel_w       - width of the S (condition select) field
//   word_w      - total microword width
//   *_lsb/_pos  - bit offsets of each microword field
// Microword layout, MSB to LSB: N[2:0], INV, S, CR[ADDR_W-1:0], CTRL[CTRL_W-1:0].
package ucode_pkg;

  typedef enum logic [2:0] {
    NS_RESET  = 3'd0,
    NS_DECODE = 3'd1,
    NS_INC    = 3'd2,
    NS_JUMP   = 3'd3,
    NS_BRANCH = 3'd4,
    NS_WAIT   = 3'd5,
    NS_CALL   = 3'd6,
    NS_RET    = 3'd7
  } next_sel_e;

  // A single condition input still needs a one-bit select field.
  function automatic int sel_w(input int cond_n);
    return (cond_n > 1) ? $clog2(cond_n) : 1;
  endfunction

  function automatic int word_w(input int addr_w, input int ctrl_w, input int cond_n);
    return 3 + 1 + sel_w(cond_n) + addr_w + ctrl_w;
  endfunction

  function automatic int cr_lsb(input int ctrl_w);
    return ctrl_w;
  endfunction

  function automatic int s_lsb(input int addr_w, input int ctrl_w);
    return ctrl_w + addr_w;
  endfunction

  function automatic int inv_pos(input int addr_w, input int ctrl_w, input int cond_n);
    return ctrl_w + addr_w + sel_w(cond_n);
  endfunction

  function automatic int n_lsb(input int addr_w, input int ctrl_w, input int cond_n);
    return ctrl_w + addr_w + sel_w(cond_n) + 1;
  endfunction

endpackage

// File: rtl/ucode_ret_stack.sv
// ucode_ret_stack: subroutine return-address stack for the microcode sequencer.
//   clk, rst_n  - clock, asynchronous active-low reset (clears the pointer only)
//   push_i      - push data_i (ignored when full)
//   pop_i       - pop top entry (ignored when empty)
//   data_i      - return address to push
//   data_o      - current top-of-stack entry (meaningless when empty)
//   empty_o     - no entries held; a pop now is an underflow
//   full_o      - STACK_D entries held; a push now is an overflow
module ucode_ret_stack #(
  parameter int STACK_D = 4,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] data_i,
  output logic [ADDR_W-1:0] data_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int SP_W  = $clog2(STACK_D + 1);
  localparam int IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

  logic [SP_W-1:0]   sp_q, sp_d;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [ADDR_W-1:0] mem_q [STACK_D];

  assign empty_o = (sp_q == '0);
  assign full_o  = (sp_q == SP_W'(STACK_D));

  // sp points at the next free slot; the top entry sits one below it.
  assign wr_idx = IDX_W'(sp_q);
  assign rd_idx = IDX_W'(sp_q - SP_W'(1));
  assign data_o = mem_q[rd_idx];

  always_comb begin
    sp_d = sp_q;
    if (push_i && !full_o) begin
      sp_d = sp_q + SP_W'(1);
    end else if (pop_i && !empty_o) begin
      sp_d = sp_q - SP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Entry storage is not reset: an entry is only read after it was pushed.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      mem_q[wr_idx] <= data_i;
    end
  end

endmodule

// File: rtl/ucode_sequencer.sv
// ucode_sequencer: writable microcode control store with next-address
// sequencer, registered control output and subroutine return stack.
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset (store contents are kept)
//   hold     - stall: freezes upc, ctrl_out, stack and stk_err
//   cond_in  - condition inputs selected by the S field
//   op_addr  - decoder entry address used by N=NS_DECODE
//   wr_en    - store write strobe (works regardless of hold)
//   wr_addr  - store write address
//   wr_data  - store write data (full microword)
//   ctrl_out - CTRL field of the word fetched in the previous cycle
//   upc      - current microaddress
//   stk_err  - sticky return-stack overflow/underflow flag
module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter int              ADDR_W     = 8,
  parameter int              CTRL_W     = 48,
  parameter int              COND_N     = 8,
  parameter int              STACK_D    = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter string           INIT_FILE  = "",
  localparam int             SEL_W      = sel_w(COND_N),
  localparam int             WORD_W     = word_w(ADDR_W, CTRL_W, COND_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic [COND_N-1:0] cond_in,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [ADDR_W-1:0] upc,
  output logic              stk_err
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int CR_LSB  = cr_lsb(CTRL_W);
  localparam int S_LSB   = s_lsb(ADDR_W, CTRL_W);
  localparam int INV_POS = inv_pos(ADDR_W, CTRL_W, COND_N);
  localparam int N_LSB   = n_lsb(ADDR_W, CTRL_W, COND_N);

  logic [WORD_W-1:0] store_q [DEPTH];

  logic [WORD_W-1:0] word;
  next_sel_e         ns;
  logic              w_inv;
  logic [SEL_W-1:0]  w_sel;
  logic [ADDR_W-1:0] w_cr;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [ADDR_W-1:0] upc_d, upc_q, upc_inc;
  logic              cond_c;
  logic              is_call, is_ret;
  logic              stk_err_d, stk_err_q;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_empty, stk_full;

  // Writes land on the edge, so a same-cycle read still sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      store_q[wr_addr] <= wr_data;
    end
  end

  assign word    = store_q[upc_q];
  assign ns      = next_sel_e'(word[N_LSB +: 3]);
  assign w_inv   = word[INV_POS];
  assign w_sel   = word[S_LSB +: SEL_W];
  assign w_cr    = word[CR_LSB +: ADDR_W];
  assign ctrl_d  = word[CTRL_W-1:0];
  assign cond_c  = cond_in[w_sel] ^ w_inv;
  assign upc_inc = upc_q + ADDR_W'(1);
  assign is_call = (ns == NS_CALL);
  assign is_ret  = (ns == NS_RET);

  always_comb begin
    upc_d = upc_inc;
    case (ns)
      NS_RESET:  upc_d = RESET_ADDR;
      NS_DECODE: upc_d = op_addr;
      NS_INC:    upc_d = upc_inc;
      NS_JUMP:   upc_d = w_cr;
      NS_BRANCH: upc_d = cond_c ? w_cr : upc_inc;
      NS_WAIT:   upc_d = cond_c ? upc_q : upc_inc;
      NS_CALL:   upc_d = w_cr;
      // Underflow falls back to the reset entry point.
      NS_RET:    upc_d = stk_empty ? RESET_ADDR : stk_top;
      default:   upc_d = RESET_ADDR;
    endcase
  end

  // A call on a full stack still jumps; only the push is lost.
  assign stk_err_d = stk_err_q | (is_call & stk_full) | (is_ret & stk_empty);

  ucode_ret_stack #(
    .STACK_D (STACK_D),
    .ADDR_W  (ADDR_W)
  ) u_ret_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (is_call & ~hold),
    .pop_i   (is_ret & ~hold),
    .data_i  (upc_inc),
    .data_o  (stk_top),
    .empty_o (stk_empty),
    .full_o  (stk_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upc_q     <= RESET_ADDR;
      ctrl_q    <= '0;
      stk_err_q <= 1'b0;
    end else if (!hold) begin
      upc_q     <= upc_d;
      ctrl_q    <= ctrl_d;
      stk_err_q <= stk_err_d;
    end
  end

  assign upc      = upc_q;
  assign ctrl_out = ctrl_q;
  assign stk_err  = stk_err_q;

endmodule

// File: tb/tb_ucode_sequencer.sv
module tb_ucode_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        hold = 1'b0;
  logic [7:0]  cond_in = '0;
  logic [7:0]  op_addr = '0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [62:0] wr_data = '0;
  logic [47:0] ctrl_out;
  logic [7:0]  upc;
  logic        stk_err;

  int vectors = 0;
  int miscompares = 0;
  bit run_cmp = 1'b0;

  ucode_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (hold),
    .cond_in  (cond_in),
    .op_addr  (op_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .ctrl_out (ctrl_out),
    .upc      (upc),
    .stk_err  (stk_err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [62:0] mem_m [256];
  logic [7:0]  upc_m = '0;
  logic [47:0] ctrl_m = '0;
  logic        err_m = 1'b0;
  logic [7:0]  stk_m [$];

  always @(negedge rst_n) begin
    upc_m = '0;
    ctrl_m = '0;
    err_m = 1'b0;
    stk_m.delete();
  end

  always @(posedge clk) begin
    logic [62:0] w;
    logic [7:0]  nxt, inc;
    logic        c;
    if (!rst_n) begin
      upc_m = '0;
      ctrl_m = '0;
      err_m = 1'b0;
      stk_m.delete();
    end else if (!hold) begin
      w   = mem_m[upc_m];
      inc = upc_m + 8'd1;
      c   = cond_in[w[58:56]] ^ w[59];
      nxt = inc;
      case (w[62:60])
        3'd0: nxt = 8'd0;
        3'd1: nxt = op_addr;
        3'd2: nxt = inc;
        3'd3: nxt = w[55:48];
        3'd4: nxt = c ? w[55:48] : inc;
        3'd5: nxt = c ? upc_m : inc;
        3'd6: begin
          if (stk_m.size() < 4) stk_m.push_back(inc);
          else err_m = 1'b1;
          nxt = w[55:48];
        end
        default: begin
          if (stk_m.size() > 0) nxt = stk_m.pop_back();
          else begin
            nxt = 8'd0;
            err_m = 1'b1;
          end
        end
      endcase
      ctrl_m = w[47:0];
      upc_m  = nxt;
    end
    if (wr_en) mem_m[wr_addr] = wr_data;
  end

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      cmp("model upc", 64'(upc), 64'(upc_m));
      cmp("model ctrl_out", 64'(ctrl_out), 64'(ctrl_m));
      cmp("model stk_err", 64'(stk_err), 64'(err_m));
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [62:0] mkw(input logic [2:0] n, input logic inv, input logic [2:0] s,
                                      input logic [7:0] cr, input logic [47:0] ctl);
    return {n, inv, s, cr, ctl};
  endfunction

  function automatic logic [62:0] fillw(input int a);
    if (a < 3) return mkw(3'd2, 1'b0, 3'd0, 8'd0, 48'(a + 1));
    if (a == 7) return mkw(3'd3, 1'b0, 3'd0, 8'd0, 48'h107);
    return mkw(3'd2, 1'b0, 3'd0, 8'd0, 48'(32'h100 + a));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [62:0] w);
    wr_en = 1'b1;
    wr_addr = 8'(a);
    wr_data = w;
    step();
    wr_en = 1'b0;
  endtask

  task automatic lit(input string nm, input int exp_upc, input logic [47:0] exp_ctrl);
    cmp({nm, " upc"}, 64'(upc), 64'(exp_upc));
    cmp({nm, " ctrl"}, 64'(ctrl_out), 64'(exp_ctrl));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 run_cmp = 1'b1;
    for (int a = 0; a < 256; a++) wr(a, fillw(a));

    // Reset and increment, hold, write-during-read
    cmp("reset ctrl_out", 64'(ctrl_out), 64'd0);
    rst_n = 1'b1;
    lit("release", 0, 48'h0);
    step(); lit("inc1", 1, 48'h1);
    step(); lit("inc2", 2, 48'h2);
    hold = 1'b1; cond_in = 8'hFF; op_addr = 8'h55;
    step(); lit("hold1", 2, 48'h2);
    step(); lit("hold2", 2, 48'h2);
    hold = 1'b0; cond_in = 8'h00;
    step(); lit("resume", 3, 48'h3);
    wr_en = 1'b1; wr_addr = 8'd3; wr_data = mkw(3'd2, 1'b0, 3'd0, 8'd0, 48'hABCD);
    step(); wr_en = 1'b0;
    lit("wr old word", 4, 48'h103);
    for (int i = 0; i < 4; i++) step();
    lit("loop back", 0, 48'h107);
    for (int i = 0; i < 4; i++) step();
    lit("wr new word", 4, 48'hABCD);

    // Decode jump
    rst_n = 1'b0;
    wr(1, mkw(3'd1, 1'b0, 3'd0, 8'd0, 48'h1D1));
    op_addr = 8'd10;
    rst_n = 1'b1;
    step(); lit("dec pre", 1, 48'h1);
    step(); lit("dec jump", 10, 48'h1D1);
    step(); lit("dec next", 11, 48'h10A);

    // Branch, async reset, wait loop
    rst_n = 1'b0;
    wr(0, mkw(3'd3, 1'b0, 3'd0, 8'd5, 48'h1));
    wr(5, mkw(3'd4, 1'b0, 3'd3, 8'd20, 48'h55));
    wr(6, mkw(3'd5, 1'b1, 3'd0, 8'd0, 48'h66));
    cond_in = 8'h08;
    rst_n = 1'b1;
    step(); lit("br jmp", 5, 48'h1);
    step(); lit("br taken", 20, 48'h55);
    rst_n = 1'b0;
    #1 lit("async rst", 0, 48'h0);
    #1 rst_n = 1'b1;
    cond_in = 8'h00;
    step(); lit("br jmp2", 5, 48'h1);
    step(); lit("br not taken", 6, 48'h55);
    for (int i = 0; i < 3; i++) begin
      step(); lit("wait", 6, 48'h66);
    end
    cond_in = 8'h01;
    step(); lit("wait exit", 7, 48'h66);

    // Call/return with overflow and underflow
    rst_n = 1'b0;
    wr(0, mkw(3'd6, 1'b0, 3'd0, 8'd30, 48'hC0));
    wr(30, mkw(3'd6, 1'b0, 3'd0, 8'd40, 48'hC1));
    wr(40, mkw(3'd6, 1'b0, 3'd0, 8'd50, 48'hC2));
    wr(50, mkw(3'd6, 1'b0, 3'd0, 8'd60, 48'hC3));
    wr(60, mkw(3'd6, 1'b0, 3'd0, 8'd70, 48'hC4));
    wr(70, mkw(3'd7, 1'b0, 3'd0, 8'd0, 48'hD0));
    wr(51, mkw(3'd7, 1'b0, 3'd0, 8'd0, 48'hD1));
    wr(41, mkw(3'd7, 1'b0, 3'd0, 8'd0, 48'hD2));
    wr(31, mkw(3'd7, 1'b0, 3'd0, 8'd0, 48'hD3));
    wr(1, mkw(3'd7, 1'b0, 3'd0, 8'd0, 48'hD4));
    rst_n = 1'b1;
    cmp("call err init", 64'(stk_err), 64'd0);
    step(); lit("call1", 30, 48'hC0);
    step(); lit("call2", 40, 48'hC1);
    step(); lit("call3", 50, 48'hC2);
    hold = 1'b1;
    step(); lit("call hold", 50, 48'hC2);
    hold = 1'b0;
    step(); lit("call4", 60, 48'hC3);
    cmp("no ovf yet", 64'(stk_err), 64'd0);
    step(); lit("call5 ovf", 70, 48'hC4);
    cmp("ovf err", 64'(stk_err), 64'd1);
    step(); lit("ret1", 51, 48'hD0);
    step(); lit("ret2", 41, 48'hD1);
    step(); lit("ret3", 31, 48'hD2);
    step(); lit("ret4", 1, 48'hD3);
    step(); lit("ret5 unf", 0, 48'hD4);
    cmp("err sticky", 64'(stk_err), 64'd1);

    // Underflow alone, err cleared by reset
    rst_n = 1'b0;
    #1 cmp("rst clears err", 64'(stk_err), 64'd0);
    wr(0, mkw(3'd7, 1'b0, 3'd0, 8'd0, 48'hEE));
    rst_n = 1'b1;
    step(); lit("unf", 0, 48'hEE);
    cmp("unf err", 64'(stk_err), 64'd1);
    step(); cmp("unf sticky", 64'(stk_err), 64'd1);

    // upc+1 wraps modulo 256
    rst_n = 1'b0;
    wr(0, mkw(3'd3, 1'b0, 3'd0, 8'd254, 48'h0));
    rst_n = 1'b1;
    step(); lit("wrap a", 254, 48'h0);
    step(); lit("wrap b", 255, 48'h1FE);
    step(); lit("wrap c", 0, 48'h1FF);

    step();
    run_cmp = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
